// File: rtl/mips_alu_mdu_if.sv
// Bus between the execute-stage control and the ALU/MDU: operands, opcode, results and the MDU handshake.
// start/busy/done: start is sampled only while busy=0 and only for MULTU/DIVU. busy is high for the whole run. done pulses for one cycle with HI/LO already updated.
interface mips_alu_mdu_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic [3:0]         ALUOperation;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [SHAMT_W-1:0] shamt;
    logic               start;
    logic [WIDTH-1:0]   ALUResult;
    logic               Zero;
    logic               Overflow;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   HI;
    logic [WIDTH-1:0]   LO;
    logic [1:0]         mdu_state;

    modport master (
        output ALUOperation, A, B, shamt, start,
        input  ALUResult, Zero, Overflow, busy, done, HI, LO, mdu_state
    );

    modport slave (
        input  ALUOperation, A, B, shamt, start,
        output ALUResult, Zero, Overflow, busy, done, HI, LO, mdu_state
    );
endinterface

// File: rtl/mips_alu_mdu.sv
// Combinational ALU plus an iterative unsigned multiply/divide unit writing HI/LO.
// Define MIPS_ALU_DIV_EN to compile in the restoring divider; otherwise DIVU is never accepted.
module mips_alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic           clk,
    input logic           reset,
    mips_alu_mdu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NOR   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_LUI   = 4'd5;
    localparam logic [3:0] OP_JAL   = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_SLT   = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
`ifdef MIPS_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'd12;
`endif
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opb;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic [WIDTH-1:0]   sum, diff, result;
    logic               ovf, big_shift;

    assign sum       = bus.A + bus.B;
    assign diff      = bus.A - bus.B;
    // Shift amounts of WIDTH or more saturate instead of wrapping.
    assign big_shift = ({1'b0, bus.shamt} >= (SHAMT_W+1)'(WIDTH));

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (bus.ALUOperation)
            OP_AND: result = bus.A & bus.B;
            OP_OR:  result = bus.A | bus.B;
            OP_NOR: result = ~(bus.A | bus.B);
            OP_ADD: begin
                result = sum;
                ovf    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_LUI: result = {bus.B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_JAL: result = bus.B;
            OP_SLL: result = big_shift ? '0 : (bus.B << bus.shamt);
            OP_SRL: result = big_shift ? '0 : (bus.B >> bus.shamt);
            OP_SRA: result = big_shift ? {WIDTH{bus.B[WIDTH-1]}}
                                       : WIDTH'($signed(bus.B) >>> bus.shamt);
            OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = '0;
        endcase
    end

    // One shift-add step: add multiplicand on LSB of multiplier, shift {acc_hi,acc_lo} right.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : {WIDTH{1'b0}})};

`ifdef MIPS_ALU_DIV_EN
    // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    // A zero divisor never borrows, so it naturally yields all-ones quotient and remainder = A.
    logic [WIDTH:0] div_trial;
    assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opb};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && bus.ALUOperation == OP_MULTU) begin
                        state  <= MUL;
                        count  <= '0;
                        acc_hi <= '0;
                        acc_lo <= bus.A;
                        opb    <= bus.B;
                    end
`ifdef MIPS_ALU_DIV_EN
                    else if (bus.start && bus.ALUOperation == OP_DIVU) begin
                        state  <= DIV;
                        count  <= '0;
                        acc_hi <= '0;
                        acc_lo <= bus.A;
                        opb    <= bus.B;
                    end
`endif
                end
                MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    count  <= count + 1'b1;
                    if (count == CNT_W'(WIDTH-1)) state <= FIN;
                end
`ifdef MIPS_ALU_DIV_EN
                DIV: begin
                    if (!div_trial[WIDTH]) begin
                        acc_hi <= div_trial[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH-1)) state <= FIN;
                end
`endif
                FIN: begin
                    hi_q   <= acc_hi;
                    lo_q   <= acc_lo;
                    done_q <= 1'b1;
                    count  <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ALUResult = result;
    assign bus.Zero      = (result == '0);
    assign bus.Overflow  = ovf;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
    assign bus.mdu_state = state;
endmodule

// File: tb/tb_mips_alu_mdu.sv
// Self-checking bench for mips_alu_mdu (WIDTH=32): combinational ops, MULTU/DIVU handshake, collisions, reset.
module tb_mips_alu_mdu;
  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_alu_mdu_if #(.WIDTH(W), .SHAMT_W(5)) bus ();
  mips_alu_mdu #(.WIDTH(W), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_hilo = 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // expected {ovf, zero, result} for add/sub, derived from a 33-bit signed sum
  function automatic logic [33:0] model_addsub(input logic sub, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = sub ? ({a[31], a} - {b[31], b}) : ({a[31], a} + {b[31], b});
    return {(s[32] != s[31]), (s[31:0] == 32'd0), s[31:0]};
  endfunction

  // drivers
  task automatic comb_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] res,
                         input logic z, input logic ov);
    logic [63:0] e;
    bus.ALUOperation = op; bus.A = a; bus.B = b; bus.shamt = sh;
    exp_q.push_back({30'd0, ov, z, res});
    #1;
    e = exp_q.pop_front();
    check({tag, "_res"}, bus.ALUResult, e[31:0]);
    check({tag, "_zero"}, bus.Zero, e[32]);
    check({tag, "_ovf"}, bus.Overflow, e[33]);
  endtask

  // Called at a negedge; returns at a negedge one cycle after done.
  task automatic mdu_run(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic collide);
    logic [63:0] e;
    int cyc;
    if (op == 4'd11) e = {32'd0, a} * {32'd0, b};
    else if (b == 32'd0) e = {a, 32'hFFFF_FFFF};
    else e = {a % b, a / b};
    exp_q.push_back(e);
    bus.ALUOperation = op; bus.A = a; bus.B = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.ALUOperation = 4'd13;
    #1;
    check({tag, "_mfhi_hold"}, bus.ALUResult, last_hilo[63:32]);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      if (collide && cyc == 5) begin
        bus.start = 1'b1; bus.ALUOperation = 4'd12; bus.A = 32'd100; bus.B = 32'd7;
      end else begin
        bus.start = 1'b0; bus.ALUOperation = 4'd13;
      end
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_busy_cycles"}, cyc, W + 1);
    check({tag, "_done"}, bus.done, 1'b1);
    e = exp_q.pop_front();
    check({tag, "_hi"}, bus.HI, e[63:32]);
    check({tag, "_lo"}, bus.LO, e[31:0]);
    bus.ALUOperation = 4'd13;
    #1;
    check({tag, "_mfhi"}, bus.ALUResult, e[63:32]);
    bus.ALUOperation = 4'd14;
    #1;
    check({tag, "_mflo"}, bus.ALUResult, e[31:0]);
    last_hilo = e;
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [33:0] m;
    logic seen;
    bus.ALUOperation = 4'd0; bus.A = '0; bus.B = '0; bus.shamt = '0; bus.start = 1'b0;
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    check("rst_state", bus.mdu_state, 2'd0);

    // combinational table
    comb_op("add_ovf", 4'd3, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1);
    comb_op("sub_zero", 4'd4, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1, 1'b0);
    comb_op("slt_neg", 4'd10, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0);
    comb_op("slt_pos", 4'd10, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 1'b0);
    comb_op("sra", 4'd9, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0);
    comb_op("srl", 4'd8, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0);
    comb_op("sll", 4'd7, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    comb_op("lui", 4'd5, 32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0, 1'b0);
    comb_op("jal", 4'd6, 32'h55, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D, 1'b0, 1'b0);
    comb_op("nor", 4'd2, 32'hF0F0_0000, 32'h0000_000F, 5'd0, 32'h0F0F_FFF0, 1'b0, 1'b0);
    comb_op("and", 4'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 32'h0F00_0F00, 1'b0, 1'b0);
    comb_op("or", 4'd1, 32'hFF00_0000, 32'h0000_00FF, 5'd0, 32'hFF00_00FF, 1'b0, 1'b0);
    comb_op("sub_ovf", 4'd4, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    comb_op("op15", 4'd15, 32'h1234, 32'h5678, 5'd3, 32'd0, 1'b1, 1'b0);
    comb_op("op_multu", 4'd11, 32'h1234, 32'h5678, 5'd3, 32'd0, 1'b1, 1'b0);
    comb_op("op_divu", 4'd12, 32'h1234, 32'h5678, 5'd3, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 3 == 0) rb = {ra[31], rb[30:0]};
      m = model_addsub(i[0], ra, rb);
      comb_op(i[0] ? "rnd_sub" : "rnd_add", i[0] ? 4'd4 : 4'd3, ra, rb, 5'd0, m[31:0], m[32], m[33]);
    end

    @(negedge clk);
    reset = 1'b0;
    mdu_run("mul_max", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    mdu_run("mul_collide", 4'd11, 32'h0001_2345, 32'h0000_BEEF, 1'b1);
    for (int i = 0; i < 3; i++) mdu_run("mul_rnd", 4'd11, $urandom, $urandom, 1'b0);
`ifdef MIPS_ALU_DIV_EN
    mdu_run("div_100_7", 4'd12, 32'd100, 32'd7, 1'b0);
    mdu_run("div_by0", 4'd12, 32'h1234, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) mdu_run("div_rnd", 4'd12, $urandom, $urandom_range(1, 70000), 1'b0);
`else
    bus.ALUOperation = 4'd12; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      seen = seen | bus.busy | bus.done;
    end
    check("nodiv_busy_done", seen, 1'b0);
    check("nodiv_hi", bus.HI, last_hilo[63:32]);
    check("nodiv_lo", bus.LO, last_hilo[31:0]);
`endif

    // reset in the middle of a multiply
    bus.ALUOperation = 4'd11; bus.A = 32'hDEAD_BEEF; bus.B = 32'h1234_5678; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_hi", bus.HI, 32'd0);
    check("mid_rst_lo", bus.LO, 32'd0);
    bus.ALUOperation = 4'd14;
    #1;
    check("mid_rst_mflo", bus.ALUResult, 32'd0);
    last_hilo = 64'd0;
    @(negedge clk);
    reset = 1'b0;
    mdu_run("mul_3x4", 4'd11, 32'd3, 32'd4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_alu_mdu.md
# mips_alu_mdu

Parametrised ALU with an attached iterative multiply/divide unit (MDU), replacing the single-cycle ALU in the datapath execute stage. It keeps the existing combinational operations and opcode encodings, and adds shifts and set-less-than. It also adds MULTU/DIVU, which run over WIDTH+1 cycles under a start/busy/done handshake and write internal HI/LO registers; MFHI/MFLO read those registers. The control unit stalls the PC on `busy`.

## Interface
- `WIDTH`, 32: datapath width. Must be even and ≥ 8.
- `SHAMT_W`, 5: shift-amount width. Must be ≥ clog2(WIDTH).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `ALUOperation` input 4: operation select.
- `A`, `B` input WIDTH: operands.
- `shamt` input SHAMT_W: shift amount.
- `start` input 1: launches MULTU/DIVU; ignored for other opcodes.
- `ALUResult` output WIDTH: combinational result.
- `Zero` output 1: high when `ALUResult == 0`.
- `Overflow` output 1: signed overflow for ADD/SUB; 0 for all other opcodes.
- `busy` output 1: MDU operation in progress.
- `done` output 1: one-cycle pulse; HI/LO updated.
- `HI`, `LO` output WIDTH: MDU result registers.

## Operation
- Combinational opcodes (result valid in the same cycle, independent of `busy`):
  - 0 AND, 1 OR, 2 NOR, 3 ADD, 4 SUB (A−B).
  - 5 LUI: {B[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 6 JAL: pass B.
  - 7 SLL: B<<shamt. 8 SRL: B>>shamt. 9 SRA: arithmetic shift of B.
  - 10 SLT: 1 if signed A<B, else 0.
  - 13 MFHI: returns HI. 14 MFLO: returns LO.
  - 11 MULTU, 12 DIVU, 15: ALUResult=0.
- Shift rules: shamt ≥ WIDTH gives 0 for SLL/SRL and WIDTH copies of B's MSB for SRA.
- Overflow: ADD sets it when operand signs match and the result sign differs. SUB sets it when operand signs differ and the result sign differs from A's.
- MDU FSM states: IDLE, MUL, DIV, FIN.
  - IDLE → MUL on start=1 with opcode 11; IDLE → DIV on start=1 with opcode 12. A, B are captured on the accepting edge.
  - MUL/DIV run WIDTH iterations under a counter (0..WIDTH-1), then go to FIN.
  - FIN → IDLE, loading HI/LO and pulsing `done`.
- MULTU: unsigned shift-add. {HI,LO} = 2·WIDTH-bit product.
- DIVU: unsigned restoring divide. LO=quotient, HI=remainder.
  - Divide by zero: LO=all ones, HI=A, same latency as a normal divide.
- start=1 while busy is ignored, and the in-flight operation is unaffected. Operand changes after acceptance have no effect.
- HI/LO change only in the FIN transition. MFHI/MFLO during busy return the previous values.
- Reset values (also applied by reset asserted mid-operation, taking effect immediately):
  - state=IDLE, counter=0, busy=0, done=0, HI=0, LO=0. Any partial result is discarded.
  - Combinational outputs follow inputs and the reset HI/LO.

## Timing
- Combinational ops: zero-cycle latency, no clock involvement.
- Accepting edge E0: start=1 sampled in IDLE with opcode 11/12.
- `busy` is high from after E0 through E(WIDTH+1), i.e. WIDTH+1 cycles.
- `done` is registered and high for exactly the one cycle after E(WIDTH+1). HI/LO hold their new values from that same cycle.
- `busy` is 0 in the `done` cycle, so a new start may be accepted at the edge ending the `done` cycle. Back-to-back operations therefore take WIDTH+2 cycles each.
- reset deassertion: the first start can be accepted at the first rising edge after release.

## Configuration
- `MIPS_ALU_DIV_EN` defined: DIV state and restoring divider compiled in, behaving as above.
- `MIPS_ALU_DIV_EN` undefined: no divider hardware, and opcode 12 is never accepted.
  - start with opcode 12 leaves busy=0 and done=0, and HI/LO are unchanged.
  - ALUResult=0 for opcode 12.
  - MULTU is unaffected.

## Test plan
All scenarios use WIDTH=32, SHAMT_W=5.
- Add/sub flags:
  - ADD 0x7FFFFFFF+0x00000001 → ALUResult=0x80000000, Overflow=1, Zero=0.
  - SUB 5−5 → ALUResult=0, Zero=1, Overflow=0.
  - SLT A=0xFFFFFFFF, B=1 → ALUResult=1.
- Shifts:
  - SRA B=0x80000000, shamt=4 → 0xF8000000.
  - SRL with the same operands → 0x08000000.
  - SLL B=1, shamt=31 → 0x80000000.
  - LUI B=0x00001234 → 0x12340000.
- Multiply handshake:
  - MULTU A=B=0xFFFFFFFF, start pulsed at E0 → busy high 33 cycles.
  - done pulses once after E33, with HI=0xFFFFFFFE, LO=0x00000001.
  - MFHI then returns 0xFFFFFFFE.
- Divide (with `MIPS_ALU_DIV_EN`):
  - DIVU 100/7 → LO=14, HI=2.
  - DIVU A=0x1234, B=0 → LO=0xFFFFFFFF, HI=0x1234, with identical timing.
- Collisions/reset:
  - Start a DIVU while MULTU is busy → ignored; MULTU result is correct.
  - Assert reset at iteration 10 → busy, done, HI, LO = 0 immediately.
  - After release, a fresh MULTU 3×4 completes with LO=12.
- Without `MIPS_ALU_DIV_EN`: DIVU start → busy and done stay 0 for 40 cycles, and HI/LO retain the prior MULTU result.
